// File: rtl/trig_stamp.sv
// trig_stamp: stamps rising edges of asynchronous triggers with ref_ts and queues them round-robin into a FIFO
module trig_stamp #(
    parameter int CHANNELS = 4,
    parameter int DEPTH = 16,
    parameter int SYNC_STAGES = 2,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                sampling_clk,
    input  logic                reset,
    input  logic [63:0]         ref_ts,
    input  logic                enable,
    input  logic [CHANNELS-1:0] trig_async,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_data,
    output logic [CW-1:0]       out_channel,
    output logic [AW:0]         fifo_count,
    output logic [15:0]         drop_count,
    output logic                overflow
);
    localparam int ARM = SYNC_STAGES + 1;
    localparam int ACW = $clog2(ARM + 1);
    localparam int NW = AW + 1;
    logic [CHANNELS-1:0] sync [SYNC_STAGES];
    logic [CHANNELS-1:0] s_prev, rise, take, drop, gnt, pend_v;
    logic [63:0] pend_ts [CHANNELS];
    logic [ACW-1:0] arm_cnt;
    logic armed, gnt_any, pop, can_push;
    logic [CW-1:0] rr_ptr, gnt_idx, cand;
    logic [64+CW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [16:0] drop_sum;
    assign armed = int'(arm_cnt) == ARM;
    assign rise = sync[SYNC_STAGES-1] & ~s_prev & {CHANNELS{armed}};
    assign out_valid = fifo_count != '0;
    assign pop = out_valid & out_ready;
    assign can_push = !fifo_count[AW] || pop;
    assign {out_channel, out_data} = out_valid ? mem[rd_ptr] : '0;
    assign take = rise & {CHANNELS{enable}} & (~pend_v | gnt);
    assign drop = rise & {CHANNELS{enable}} & pend_v & ~gnt;
    assign drop_sum = {1'b0, drop_count} + 17'($countones(drop));
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = CW'((int'(rr_ptr) + i) % CHANNELS);
            if (!gnt_any && can_push && pend_v[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt = '0;
        gnt[gnt_idx] = gnt_any;
    end
    always_ff @(posedge sampling_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
            for (int c = 0; c < CHANNELS; c++) pend_ts[c] <= '0;
            s_prev <= '0;
            arm_cnt <= '0;
            pend_v <= '0;
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            drop_count <= '0;
            overflow <= 1'b0;
        end else begin
            sync[0] <= trig_async;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            s_prev <= sync[SYNC_STAGES-1];
            if (!armed) arm_cnt <= arm_cnt + ACW'(1);
            pend_v <= take | (pend_v & ~gnt);
            for (int c = 0; c < CHANNELS; c++) if (take[c]) pend_ts[c] <= ref_ts;
            if (gnt_any) begin
                rr_ptr <= (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + CW'(1);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + NW'(gnt_any) - NW'(pop);
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            overflow <= overflow | (|drop);
        end
    end
    always_ff @(posedge sampling_clk) if (gnt_any) mem[wr_ptr] <= {gnt_idx, pend_ts[gnt_idx]};
endmodule

// File: tb/tb_trig_stamp.sv
// tb_trig_stamp: directed and randomized checks of trig_stamp against a timestamp-history reference model
module tb_trig_stamp;
    localparam int CH = 4;
    localparam int DEPTH = 16;
    localparam int S = 2;
    localparam int HMAX = 8192;
    logic sampling_clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic out_ready = 1'b0;
    logic [63:0] ref_ts = '0;
    logic [CH-1:0] trig_async = '0;
    logic out_valid;
    logic [63:0] out_data;
    logic [1:0] out_channel;
    logic [4:0] fifo_count;
    logic [15:0] drop_count;
    logic overflow;
    int checks = 0;
    int errors = 0;
    int pc = 0;
    logic ref_auto = 1'b0;
    logic [63:0] ref_base = '0;
    logic [63:0] ref_fixed = '0;
    logic [63:0] hist [HMAX];
    int expk [CH][$];
    logic [1:0] got_ch [$];
    logic [63:0] got_ts [$];

    trig_stamp #(.CHANNELS(CH), .DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
        .sampling_clk(sampling_clk), .reset(reset), .ref_ts(ref_ts), .enable(enable),
        .trig_async(trig_async), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_channel(out_channel), .fifo_count(fifo_count),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 sampling_clk = ~sampling_clk;

    always @(posedge sampling_clk) begin
        hist[pc % HMAX] <= ref_ts;
        pc <= pc + 1;
    end

    always @(negedge sampling_clk) ref_ts = ref_auto ? ref_base + 64'(pc) * 64'd3 : ref_fixed;

    // An edge first sampled at posedge k is stamped with ref as seen at posedge k+S.
    function automatic logic [63:0] exp_ts(input int k);
        return hist[(k + S) % HMAX];
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        ref_auto = 1'b0;
        out_ready = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge sampling_clk);
        reset = 1'b0;
        repeat (4) @(negedge sampling_clk);
        for (int c = 0; c < CH; c++) expk[c].delete();
        got_ch.delete();
        got_ts.delete();
    endtask

    task automatic pulse(input int c);
        trig_async[c] = 1'b1;
        expk[c].push_back(pc);
        repeat (2) @(negedge sampling_clk);
        trig_async[c] = 1'b0;
        repeat (2) @(negedge sampling_clk);
    endtask

    task automatic collect(input int n, input int budget);
        int target;
        target = got_ts.size() + n;
        out_ready = 1'b1;
        for (int t = 0; t < budget && got_ts.size() < target; t++) begin
            if (out_valid) begin
                got_ch.push_back(out_channel);
                got_ts.push_back(out_data);
            end
            @(negedge sampling_clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rst_data got %h want 0", out_data); end
        checks++; if (out_channel !== 2'd0) begin errors++; $display("FAIL rst_channel got %0d want 0", out_channel); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drops got %0d want 0", drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
    endtask

    task automatic test_single_edge();
        apply_reset();
        ref_fixed = 64'h0000_0001_0000_0005;
        @(negedge sampling_clk);
        trig_async[2] = 1'b1;
        repeat (S + 1) @(negedge sampling_clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL se_early_valid got %b want 0", out_valid); end
        @(negedge sampling_clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL se_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 64'h0000_0001_0000_0005) begin errors++; $display("FAIL se_data got %h want 0000000100000005", out_data); end
        checks++; if (out_channel !== 2'd2) begin errors++; $display("FAIL se_channel got %0d want 2", out_channel); end
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL se_count got %0d want 1", fifo_count); end
        out_ready = 1'b1;
        @(negedge sampling_clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL se_pop_valid got %b want 0", out_valid); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL se_pop_count got %0d want 0", fifo_count); end
        trig_async[2] = 1'b0;
        repeat (2) @(negedge sampling_clk);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        ref_fixed = 64'h10;
        @(negedge sampling_clk);
        trig_async = '1;
        repeat (8) @(negedge sampling_clk);
        checks++; if (fifo_count !== 5'd4) begin errors++; $display("FAIL sim_count got %0d want 4", fifo_count); end
        collect(4, 20);
        checks++; if (got_ts.size() != 4) begin errors++; $display("FAIL sim_entries got %0d want 4", got_ts.size()); end
        for (int i = 0; i < got_ts.size(); i++) begin
            checks++; if (got_ch[i] !== 2'(i)) begin errors++; $display("FAIL sim_order[%0d] got %0d want %0d", i, got_ch[i], i); end
            checks++; if (got_ts[i] !== 64'h10) begin errors++; $display("FAIL sim_data[%0d] got %h want 10", i, got_ts[i]); end
        end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL sim_drops got %0d want 0", drop_count); end
        trig_async = '0;
        repeat (2) @(negedge sampling_clk);
    endtask

    task automatic test_backpressure();
        int left;
        apply_reset();
        ref_base = 64'h0000_0200_0000_0000;
        ref_auto = 1'b1;
        for (int j = 0; j < 19; j++) begin
            pulse((j % 2 != 0) ? 3 : 1);
            if (j >= DEPTH + 2) void'(expk[(j % 2 != 0) ? 3 : 1].pop_back());
        end
        repeat (4) @(negedge sampling_clk);
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL bp_count got %0d want 16", fifo_count); end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL bp_drops got %0d want 1", drop_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", overflow); end
        collect(18, 100);
        checks++; if (got_ts.size() != 18) begin errors++; $display("FAIL bp_entries got %0d want 18", got_ts.size()); end
        for (int i = 0; i < got_ts.size(); i++) begin
            int c;
            c = int'(got_ch[i]);
            checks++;
            if (expk[c].size() == 0) begin errors++; $display("FAIL bp_extra[%0d] ch %0d got %h want none", i, c, got_ts[i]); end
            else begin
                logic [63:0] w;
                w = exp_ts(expk[c].pop_front());
                if (got_ts[i] !== w) begin errors++; $display("FAIL bp_data[%0d] ch %0d got %h want %h", i, c, got_ts[i], w); end
            end
        end
        left = 0;
        for (int c = 0; c < CH; c++) left += expk[c].size();
        checks++; if (left != 0) begin errors++; $display("FAIL bp_missing got %0d want 0", left); end
        repeat (3) @(negedge sampling_clk);
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL bp_drained got %0d want 0", fifo_count); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        ref_base = 64'h0000_0300_0000_0000;
        ref_auto = 1'b1;
        for (int j = 0; j < DEPTH - 1; j++) pulse(3);
        repeat (2) @(negedge sampling_clk);
        checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL rr_fill got %0d want 15", fifo_count); end
        for (int n = 0; n < 32; n++) begin
            if (n % 4 == 0) begin
                trig_async[0] = 1'b1;
                trig_async[3] = 1'b1;
                expk[0].push_back(pc);
                expk[3].push_back(pc);
            end else if (n % 4 == 2) begin
                trig_async[0] = 1'b0;
                trig_async[3] = 1'b0;
            end
            out_ready = (n % 2 == 0);
            if (out_ready && out_valid) begin
                got_ch.push_back(out_channel);
                got_ts.push_back(out_data);
            end
            @(negedge sampling_clk);
        end
        out_ready = 1'b0;
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rr_drops got %0d want 0", drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rr_overflow got %b want 0", overflow); end
        collect(31 - got_ts.size(), 100);
        checks++; if (got_ts.size() != 31) begin errors++; $display("FAIL rr_entries got %0d want 31", got_ts.size()); end
        for (int i = 0; i < got_ts.size(); i++) begin
            int c;
            int wc;
            c = int'(got_ch[i]);
            wc = (i < 15) ? 3 : (((i - 15) % 2 != 0) ? 3 : 0);
            checks++; if (c != wc) begin errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, c, wc); end
            checks++;
            if (expk[c].size() == 0) begin errors++; $display("FAIL rr_extra[%0d] ch %0d got %h want none", i, c, got_ts[i]); end
            else begin
                logic [63:0] w;
                w = exp_ts(expk[c].pop_front());
                if (got_ts[i] !== w) begin errors++; $display("FAIL rr_data[%0d] ch %0d got %h want %h", i, c, got_ts[i], w); end
            end
        end
    endtask

    task automatic test_reset_enable();
        int k;
        apply_reset();
        ref_base = 64'h0000_0400_0000_0000;
        ref_auto = 1'b1;
        for (int j = 0; j < 5; j++) pulse(1);
        repeat (2) @(negedge sampling_clk);
        checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL re_fill got %0d want 5", fifo_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL re_async_valid got %b want 0", out_valid); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL re_async_count got %0d want 0", fifo_count); end
        trig_async[0] = 1'b1;
        repeat (2) @(negedge sampling_clk);
        reset = 1'b0;
        repeat (10) @(negedge sampling_clk);
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL re_held_high got %0d want 0", fifo_count); end
        trig_async[0] = 1'b0;
        repeat (2) @(negedge sampling_clk);
        trig_async[0] = 1'b1;
        k = pc;
        repeat (S + 3) @(negedge sampling_clk);
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL re_rearm_count got %0d want 1", fifo_count); end
        checks++; if (out_channel !== 2'd0) begin errors++; $display("FAIL re_rearm_channel got %0d want 0", out_channel); end
        checks++; if (out_data !== exp_ts(k)) begin errors++; $display("FAIL re_rearm_data got %h want %h", out_data, exp_ts(k)); end
        collect(1, 10);
        trig_async[0] = 1'b0;
        enable = 1'b0;
        trig_async[1] = 1'b1;
        repeat (6) @(negedge sampling_clk);
        enable = 1'b1;
        repeat (6) @(negedge sampling_clk);
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL re_disabled_count got %0d want 0", fifo_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL re_disabled_drops got %0d want 0", drop_count); end
        trig_async[1] = 1'b0;
        repeat (2) @(negedge sampling_clk);
    endtask

    task automatic test_random();
        int n_edges;
        int left;
        apply_reset();
        ref_base = {$urandom(), 32'h0};
        ref_auto = 1'b1;
        n_edges = 0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(7) == 0) begin
                    trig_async[c] = ~trig_async[c];
                    if (trig_async[c]) begin
                        expk[c].push_back(pc);
                        n_edges++;
                    end
                end
            end
            out_ready = ($urandom_range(1) == 1);
            if (out_ready && out_valid) begin
                got_ch.push_back(out_channel);
                got_ts.push_back(out_data);
            end
            @(negedge sampling_clk);
        end
        out_ready = 1'b0;
        collect(n_edges - got_ts.size(), 300);
        checks++; if (got_ts.size() != n_edges) begin errors++; $display("FAIL rnd_entries got %0d want %0d", got_ts.size(), n_edges); end
        for (int i = 0; i < got_ts.size(); i++) begin
            int c;
            c = int'(got_ch[i]);
            checks++;
            if (expk[c].size() == 0) begin errors++; $display("FAIL rnd_extra[%0d] ch %0d got %h want none", i, c, got_ts[i]); end
            else begin
                logic [63:0] w;
                w = exp_ts(expk[c].pop_front());
                if (got_ts[i] !== w) begin errors++; $display("FAIL rnd_data[%0d] ch %0d got %h want %h", i, c, got_ts[i], w); end
            end
        end
        left = 0;
        for (int c = 0; c < CH; c++) left += expk[c].size();
        checks++; if (left != 0) begin errors++; $display("FAIL rnd_missing got %0d want 0", left); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rnd_drops got %0d want 0", drop_count); end
        trig_async = '0;
    endtask

    initial begin
        @(negedge sampling_clk);
        test_reset();
        test_single_edge();
        test_simultaneous();
        test_backpressure();
        test_round_robin();
        test_reset_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trig_stamp.md
Name: trig_stamp

Overview:
- Downstream consumer of the 64-bit `ref` timestamp produced by the reference counter in the `sampling_clk` domain.
- Synchronises CHANNELS asynchronous trigger inputs and detects each rising edge.
- On each edge, latches the current `ref` into a per-channel pending slot.
- A round-robin arbiter moves pending stamps into a DEPTH-entry FIFO, read out over a valid/ready stream with drop accounting.

Parameters:
- CHANNELS, 4, number of trigger inputs (1..16).
- DEPTH, 16, FIFO entries (power of 2, >=2).
- SYNC_STAGES, 2, synchroniser flops per input (>=2).

Ports:
- sampling_clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ref  in  64  timestamp from the reference counter, sampled as-is.
- enable  in  1  edges are stamped only while high.
- trig_async  in  CHANNELS  asynchronous trigger inputs.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  64  stamped `ref` value of the head entry.
- out_channel  out  CW  channel index of the head entry; CW = max(1, clog2(CHANNELS)).
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
- drop_count  out  16  saturating count of dropped edges.
- overflow  out  1  sticky; set on the first drop.

Behaviour:
- **Reset:** asynchronous assert clears all of the following:
  - sync chains and edge-history flops;
  - pending valid bits;
  - FIFO pointers and count;
  - arbiter pointer (to channel 0);
  - drop_count and overflow.
  - Outputs during reset: out_valid=0, out_data=0, out_channel=0, fifo_count=0, drop_count=0, overflow=0.
  - Reset may assert at any point; state is discarded and nothing is flushed out.
- **Post-reset arming:** edge detection is masked for SYNC_STAGES+1 cycles after reset release. An input already high at release produces no stamp; only a later 0->1 transition does.
- **Edge detect:** edge[c] = s_last[c] & ~s_prev[c], one cycle wide.
- **Timing, with input first sampled high at posedge k:**
  - edge[c] is high during cycle k+SYNC_STAGES-1 .. k+SYNC_STAGES.
  - pending[c] captures `ref` at posedge k+SYNC_STAGES.
  - Earliest FIFO write is at posedge k+SYNC_STAGES+1.
  - out_valid rises after that edge if the FIFO was empty, giving a fixed latency of SYNC_STAGES+1 clocks.
- **Pending slot, one per channel (valid bit, 64-bit stamp):**
  - Edge with enable=0: ignored, not counted.
  - Edge with enable=1 and the slot empty, or the slot granted in the same cycle: capture; the slot is full next cycle.
  - Edge with enable=1 and the slot full and not granted: drop. drop_count increments, saturating at 0xFFFF; overflow is set.
- **Arbiter:**
  - Each cycle, grants at most one full pending slot, searching round-robin from the pointer.
  - After a grant, pointer = granted+1 mod CHANNELS.
  - Grant is allowed only if the FIFO can accept: fifo_count<DEPTH, or a pop occurs in the same cycle.
  - No grant leaves the pointer unchanged.
- **FIFO:**
  - Show-ahead.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop keeps fifo_count unchanged, including when full.
  - out_valid = (fifo_count != 0).
  - out_data and out_channel are stable while out_valid=1 and out_ready=0.
  - No pop when empty.
  - Pointers wrap modulo DEPTH.
- **Ordering:**
  - Entries from one channel emerge in edge order.
  - Across channels, order is the arbiter grant order.
  - Simultaneous edges carry identical `ref`.
- **Inactive inputs:** enable and out_ready have no effect on the sync chains.

Test Plan:
- **Single edge:** reset released, 4 idle cycles, ref held at 0x0000_0001_0000_0005, trig_async[2] 0->1 sampled at posedge k -> out_valid rises after posedge k+3, out_data=0x0000_0001_0000_0005, out_channel=2, fifo_count=1; pop with out_ready=1 -> out_valid=0.
- **Simultaneous edges:** all 4 channels rise at the same posedge with ref=0x10 -> four entries, channels 0,1,2,3 in that order, all out_data=0x10, drop_count=0.
- **Backpressure/drop:**
  - out_ready=0 while 19 edges are issued on channel 1 and channel 3 alternately; each edge is spaced 4 cycles from the previous one.
  - Required: FIFO holds 16 entries, fifo_count=16, both pending slots are full, drop_count=1, overflow=1.
  - Then out_ready=1 -> 18 entries drain with no duplicates and ref strictly increasing per channel.
- **Round-robin fairness:** channels 0 and 3 toggle every 2 cycles with the FIFO nearly full and out_ready pulsed -> grants alternate 0,3,0,3, and neither channel drops while the other is served.
- **Reset/enable:**
  - Reset asserted with 5 entries queued -> out_valid=0 and fifo_count=0 immediately, asynchronously.
  - trig_async[0] held high across reset release -> no entry; a later 0->1 transition produces one entry.
  - enable=0 during an edge -> no entry and drop_count unchanged.
